// File: rtl/serial_pkg.sv
// Shared definitions for the board-level serial link (transmitter and receiver).
package serial_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] SHIFT_ENC = 2'd1;
    localparam logic [1:0] GAP_ENC   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        SHIFT = SHIFT_ENC,
        GAP   = GAP_ENC
    } state_t;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage : serial_pkg

// File: rtl/bit_tick_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count with a one-cycle tick.
module bit_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge values of its neighbours; blocking = here would create order races.
    always_ff @(posedge CLOCK) begin
        if (RESET || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule : bit_tick_gen

// File: rtl/serial_shift_tx.sv
// Parallel-to-serial transmitter: one word per valid/ready handshake, shifted
// out MSB-first with a frame strobe, followed by one idle bit period.
module serial_shift_tx
    import serial_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_data,
    output logic             ser_frame,
    output logic             tx_done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nx;
    logic             tx_ready_nx, ser_data_nx, ser_frame_nx, tx_done_nx;
    logic             accept, tick_en, tick;

    assign accept  = (state == IDLE) && tx_valid && tx_ready;
    assign tick_en = (state == SHIFT) || (state == GAP);

    bit_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .enable(tick_en),
        .clear (accept),
        .tick  (tick)
    );

    // Outputs are computed one cycle ahead so they can leave straight from flops.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which is what would otherwise infer a latch.
        state_nx     = state;
        shreg_nx     = shreg;
        bit_cnt_nx   = bit_cnt;
        tx_ready_nx  = tx_ready;
        ser_data_nx  = ser_data;
        ser_frame_nx = ser_frame;
        tx_done_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx     = SHIFT;
                    shreg_nx     = tx_data;
                    bit_cnt_nx   = '0;
                    ser_data_nx  = tx_data[WIDTH-1];
                    ser_frame_nx = 1'b1;
                    tx_ready_nx  = 1'b0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nx     = GAP;
                        bit_cnt_nx   = '0;
                        ser_data_nx  = 1'b0;
                        ser_frame_nx = 1'b0;
                        tx_done_nx   = 1'b1;
                    end else begin
                        shreg_nx    = shreg << 1;
                        bit_cnt_nx  = bit_cnt + BCW'(1);
                        ser_data_nx = shreg_nx[WIDTH-1];
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    state_nx    = IDLE;
                    tx_ready_nx = 1'b1;
                end
            end
            default: begin
                state_nx     = IDLE;
                bit_cnt_nx   = '0;
                tx_ready_nx  = 1'b1;
                ser_data_nx  = 1'b0;
                ser_frame_nx = 1'b0;
            end
        endcase
    end

    // The shift register is cleared on reset too, so an abandoned word leaves no residue.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            tx_ready  <= 1'b1;
            ser_data  <= 1'b0;
            ser_frame <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_nx;
            shreg     <= shreg_nx;
            bit_cnt   <= bit_cnt_nx;
            tx_ready  <= tx_ready_nx;
            ser_data  <= ser_data_nx;
            ser_frame <= ser_frame_nx;
            tx_done   <= tx_done_nx;
        end
    end

endmodule : serial_shift_tx

// File: tb/tb_serial_shift_tx.sv
// Directed bench for serial_shift_tx: default instance (8 bits, 4 clocks/bit)
// and an edge-parameter instance (4 bits, 1 clock/bit).
module tb_serial_shift_tx;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ser_data, ser_frame, tx_done;

    logic [3:0] e_data = '0;
    logic       e_valid = 1'b0;
    logic       e_ready, e_sdata, e_frame, e_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int last_acc = 0;
    int done_cnt = 0;
    int e_acc_cnt  = 0;
    int e_last_acc = 0;
    int e_done_cnt = 0;

    serial_shift_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ser_data(ser_data), .ser_frame(ser_frame), .tx_done(tx_done)
    );

    serial_shift_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut_e (
        .CLOCK(CLOCK), .RESET(RESET), .tx_data(e_data), .tx_valid(e_valid),
        .tx_ready(e_ready), .ser_data(e_sdata), .ser_frame(e_frame), .tx_done(e_done)
    );

    always #5 CLOCK = ~CLOCK;

    // Event logger: accept edges and done pulses, seen at each rising edge.
    always @(posedge CLOCK) begin
        cyc <= cyc + 1;
        if (!RESET && tx_valid && tx_ready === 1'b1) begin
            acc_cnt  <= acc_cnt + 1;
            last_acc <= cyc;
        end
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (!RESET && e_valid && e_ready === 1'b1) begin
            e_acc_cnt  <= e_acc_cnt + 1;
            e_last_acc <= cyc;
        end
        if (e_done === 1'b1) e_done_cnt <= e_done_cnt + 1;
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({tx_ready, ser_frame, ser_data, tx_done} !== 4'b1000) begin
                n_fail++;
                $display("FAIL reset_hold%0d: {ready,frame,data,done}=%b expected 1000", i,
                         {tx_ready, ser_frame, ser_data, tx_done});
            end
        end
        tx_valid = 1'b0;
        RESET    = 1'b0;
        step();
        n_checks++;
        if (acc_cnt !== 0 || {tx_ready, ser_frame} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_no_accept: accepts=%0d ready,frame=%b expected 0 and 10",
                     acc_cnt, {tx_ready, ser_frame});
        end
    endtask

    task automatic test_single();
        logic [7:0] word = 8'hA5;
        logic [3:0] obs, expv;
        int k_cyc, acc0, done0, guard;
        acc0 = acc_cnt; done0 = done_cnt;
        tx_data = word; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        k_cyc = cyc;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            expv = {1'b0, 1'b1, word[7 - j / 4], 1'b0};
            obs  = {tx_ready, ser_frame, ser_data, tx_done};
            n_checks++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL single_bit_cycle%0d: {ready,frame,data,done}=%b expected %b", j, obs, expv);
            end
        end
        step();
        n_checks++;
        if ({tx_ready, ser_frame, ser_data, tx_done} !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_frame_end: {ready,frame,data,done}=%b expected 0001",
                     {tx_ready, ser_frame, ser_data, tx_done});
        end
        step();
        n_checks++;
        if (tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done_width: tx_done=%b expected 0", tx_done);
        end
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        n_checks++;
        if (cyc - k_cyc !== 36) begin
            n_fail++;
            $display("FAIL single_ready_latency: %0d cycles expected 36", cyc - k_cyc);
        end
        n_checks++;
        if (done_cnt - done0 !== 1 || acc_cnt - acc0 !== 1) begin
            n_fail++;
            $display("FAIL single_counts: done=%0d accepts=%0d expected 1 and 1",
                     done_cnt - done0, acc_cnt - acc0);
        end
    endtask

    task automatic test_back_to_back();
        int a1, acc0, guard;
        acc0 = acc_cnt;
        tx_data = 8'hFF; tx_valid = 1'b1;
        step();
        a1 = last_acc;
        tx_data = 8'h00;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            n_checks++;
            if ({ser_frame, ser_data} !== 2'b11) begin
                n_fail++;
                $display("FAIL b2b_first_bit_cycle%0d: frame,data=%b expected 11", j, {ser_frame, ser_data});
            end
        end
        guard = 0;
        while (acc_cnt - acc0 < 2 && guard < 60) begin
            step();
            guard++;
        end
        tx_valid = 1'b0;
        n_checks++;
        if (last_acc - a1 !== 37 || acc_cnt - acc0 !== 2) begin
            n_fail++;
            $display("FAIL b2b_period: %0d cycles (%0d accepts) expected 37 (2)", last_acc - a1, acc_cnt - acc0);
        end
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            n_checks++;
            if ({ser_frame, ser_data} !== 2'b10) begin
                n_fail++;
                $display("FAIL b2b_second_bit_cycle%0d: frame,data=%b expected 10", j, {ser_frame, ser_data});
            end
        end
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
    endtask

    task automatic test_isolation();
        logic [7:0] word = 8'h3C;
        int acc0, done0, guard;
        acc0 = acc_cnt; done0 = done_cnt;
        tx_data = word; tx_valid = 1'b1;
        step();
        tx_data = 8'hFF; tx_valid = 1'b0;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            tx_valid = ~tx_valid;
            n_checks++;
            if ({ser_frame, ser_data} !== {1'b1, word[7 - j / 4]}) begin
                n_fail++;
                $display("FAIL iso_bit_cycle%0d: frame,data=%b expected %b", j,
                         {ser_frame, ser_data}, {1'b1, word[7 - j / 4]});
            end
        end
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 60) begin
            step();
            tx_valid = ~tx_valid;
            guard++;
        end
        tx_valid = 1'b0;
        n_checks++;
        if (acc_cnt - acc0 !== 1 || done_cnt - done0 !== 1) begin
            n_fail++;
            $display("FAIL iso_counts: accepts=%0d done=%0d expected 1 and 1", acc_cnt - acc0, done_cnt - done0);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] word = 8'h81;
        int acc0, done0, guard, k_cyc;
        acc0 = acc_cnt; done0 = done_cnt;
        tx_data = 8'hF0; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int j = 0; j < 12; j++) step();
        n_checks++;
        if ({ser_frame, ser_data} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_bit3: frame,data=%b expected 11", {ser_frame, ser_data});
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if ({tx_ready, ser_frame, ser_data, tx_done} !== 4'b1000) begin
            n_fail++;
            $display("FAIL mid_reset_values: {ready,frame,data,done}=%b expected 1000",
                     {tx_ready, ser_frame, ser_data, tx_done});
        end
        for (int j = 0; j < 40; j++) step();
        n_checks++;
        if (done_cnt - done0 !== 0 || ser_frame !== 1'b0 || tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_abandoned: done=%0d frame=%b ready=%b expected 0,0,1",
                     done_cnt - done0, ser_frame, tx_ready);
        end
        tx_data = word; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        k_cyc = cyc;
        for (int j = 0; j < 32; j++) begin
            if (j > 0) step();
            n_checks++;
            if ({ser_frame, ser_data} !== {1'b1, word[7 - j / 4]}) begin
                n_fail++;
                $display("FAIL mid_next_bit_cycle%0d: frame,data=%b expected %b", j,
                         {ser_frame, ser_data}, {1'b1, word[7 - j / 4]});
            end
        end
        guard = 0;
        while (tx_ready !== 1'b1 && guard < 60) begin
            step();
            guard++;
        end
        n_checks++;
        if (cyc - k_cyc !== 36 || done_cnt - done0 !== 1 || acc_cnt - acc0 !== 2) begin
            n_fail++;
            $display("FAIL mid_next_word: latency=%0d done=%0d accepts=%0d expected 36,1,2",
                     cyc - k_cyc, done_cnt - done0, acc_cnt - acc0);
        end
    endtask

    task automatic test_edge_params();
        logic [3:0] word = 4'b1001;
        int a1, acc0, done0, guard;
        acc0 = e_acc_cnt; done0 = e_done_cnt;
        e_data = word; e_valid = 1'b1;
        step();
        a1 = e_last_acc;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) step();
            n_checks++;
            if ({e_frame, e_sdata} !== {1'b1, word[3 - j]}) begin
                n_fail++;
                $display("FAIL edge_bit%0d: frame,data=%b expected %b", j, {e_frame, e_sdata}, {1'b1, word[3 - j]});
            end
        end
        step();
        n_checks++;
        if ({e_ready, e_frame, e_sdata, e_done} !== 4'b0001) begin
            n_fail++;
            $display("FAIL edge_frame_end: {ready,frame,data,done}=%b expected 0001",
                     {e_ready, e_frame, e_sdata, e_done});
        end
        step();
        n_checks++;
        if ({e_ready, e_done} !== 2'b10 || e_done_cnt - done0 !== 1) begin
            n_fail++;
            $display("FAIL edge_done_once: ready,done=%b pulses=%0d expected 10 and 1",
                     {e_ready, e_done}, e_done_cnt - done0);
        end
        guard = 0;
        while (e_acc_cnt - acc0 < 2 && guard < 20) begin
            step();
            guard++;
        end
        e_valid = 1'b0;
        n_checks++;
        if (e_last_acc - a1 !== 6 || e_acc_cnt - acc0 !== 2) begin
            n_fail++;
            $display("FAIL edge_period: %0d cycles (%0d accepts) expected 6 (2)", e_last_acc - a1, e_acc_cnt - acc0);
        end
        for (int j = 0; j < 8; j++) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_isolation();
        test_reset_mid();
        test_edge_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_shift_tx
